modport_dut: RTL and testbench
==============================

Name: modport_dut

Overview:
- Memory-mapped DMA controller register block with a small built-in transfer engine.
- Sits behind a simple single-cycle register bus (wr_en, rd_en, addr, wdata, rdata) driven by the RAL-based environment.
- Holds DMA configuration registers and reports engine status and counters through read-only registers.

Parameters:
- BASE_ADDR, 32'h400, byte address of the first register; register offsets are relative to it.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-high reset; the name follows codebase convention and does not indicate polarity.
- wr_en  in  1  write strobe.
- rd_en  in  1  read strobe.
- addr  in  32  byte address; word aligned, addr[1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data.

Behaviour:
- Register map (offset, access, reset value):
  - +0x00 INTR, RW: [15:0] intr_status, [31:16] intr_mask; reset 0. Engine completion sets intr_status[0]; a bus write in the same cycle loses to this set.
  - +0x04 CTRL, RW: [0] start_dma, [7:1] w_count, [8] io_mem, [31:9] read 0; reset 0.
  - +0x08 IO_ADDR, RW 32; reset 0.
  - +0x0C MEM_ADDR, RW 32; reset 0.
  - +0x10 EXTRA_INFO, RW 32; reset 0.
  - +0x14 STATUS, RO: [0] busy, [1] done, [2] error, [31:3] 0; reset 0.
  - +0x18 TRANSFER_COUNT, RO 32; reset 0.
  - +0x1C DESCRIPTOR_ADDR, RW 32; reset 0.
  - +0x20 ERROR_STATUS, W1C: [0] zero_count, [1] unmapped (feature only), [2] ctrl_while_busy; reset 0.
  - +0x24 CONFIG, RW 32; reset 0.
- Writes:
  - Take effect at the posedge where wr_en=1.
  - Writes to RO registers are ignored.
  - Unmapped writes are ignored.
- Reads:
  - rdata is registered: it loads the addressed value at the posedge where rd_en=1 and holds otherwise.
  - One-cycle latency.
  - Unmapped reads return 0.
- wr_en and rd_en asserted together on the same address: the read returns the pre-write value.
- Engine states: IDLE, RUN, DONE.
  - IDLE -> RUN: CTRL write with start_dma=1 and w_count!=0. Load cnt=w_count, set busy=1, clear done.
  - CTRL write with start_dma=1 and w_count=0: set ERROR_STATUS[0] and STATUS.error; stay IDLE.
  - RUN: cnt decrements each cycle. When cnt==1 -> DONE on the next edge.
  - DONE (one cycle): busy=0, done=1, TRANSFER_COUNT += w_count (wraps at 2^32), intr_status[0]=1, CTRL.start_dma self-clears, -> IDLE.
  - Busy interval equals w_count cycles.
- CTRL write while busy: ignored entirely, and ERROR_STATUS[2] plus STATUS.error are set.
- STATUS.error is the OR of the ERROR_STATUS bits. Clearing ERROR_STATUS via W1C clears it.
- Reset mid-transfer: all registers, counters and the engine return to reset values on the next edge.

Optional Feature:
- Macro MODPORT_UNMAPPED_ERR_EN.
- Defined:
  - An access to an unmapped offset sets ERROR_STATUS[1].
  - An unmapped read returns 32'hDEAD_BEEF.
- Undefined: ERROR_STATUS[1] is constant 0 and unmapped reads return 0.

Decomposition:
- Package modport_pkg holds:
  - register offset localparams;
  - CTRL field bit positions;
  - the engine state enum (IDLE, RUN, DONE);
  - ERROR_STATUS bit indices.
- One sub-module, modport_engine, contains the state machine, the countdown counter and the TRANSFER_COUNT accumulator.
- Register decode and read mux stay in the top module.

Test Plan:
- Reset, then read all 10 offsets -> each returns 0; read data appears one cycle after rd_en.
- Write 0x1234_5678 to IO_ADDR, then read it back -> 0x1234_5678. Write 0xFFFF_FFFF to CTRL, then read -> 0x0000_01FF.
- Write CTRL = start_dma=1, w_count=5 (0x0B):
  - STATUS.busy=1 for 5 cycles, then STATUS=0x2;
  - TRANSFER_COUNT=5, INTR[0]=1, CTRL[0]=0.
- Write CTRL=0x01 (w_count=0) -> ERROR_STATUS=0x1 and STATUS.error=1. Write 0x1 to ERROR_STATUS -> both clear.
- Start with w_count=10, then write CTRL again mid-transfer -> ERROR_STATUS[2]=1; TRANSFER_COUNT ends at 10.
- Access offset 0x40:
  - without the macro: read 0, no error bit;
  - with MODPORT_UNMAPPED_ERR_EN: read 0xDEADBEEF and ERROR_STATUS[1]=1.

Source files
------------

// File: rtl/modport_pkg.sv
// Shared definitions for the DMA register block: register offsets, CTRL layout,
// error bit indices and engine state encoding.
package modport_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFF_W    = 8;
  localparam int unsigned WCOUNT_W = 7;
  localparam int unsigned INTR_W   = 16;
  localparam int unsigned ERR_W    = 3;

  // Register byte offsets relative to BASE_ADDR
  localparam logic [OFF_W-1:0] OFF_INTR       = 8'h00;
  localparam logic [OFF_W-1:0] OFF_CTRL       = 8'h04;
  localparam logic [OFF_W-1:0] OFF_IO_ADDR    = 8'h08;
  localparam logic [OFF_W-1:0] OFF_MEM_ADDR   = 8'h0C;
  localparam logic [OFF_W-1:0] OFF_EXTRA_INFO = 8'h10;
  localparam logic [OFF_W-1:0] OFF_STATUS     = 8'h14;
  localparam logic [OFF_W-1:0] OFF_XFER_COUNT = 8'h18;
  localparam logic [OFF_W-1:0] OFF_DESC_ADDR  = 8'h1C;
  localparam logic [OFF_W-1:0] OFF_ERR_STATUS = 8'h20;
  localparam logic [OFF_W-1:0] OFF_CONFIG     = 8'h24;

  // CTRL field bit positions
  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_WCOUNT_LSB = 1;
  localparam int unsigned CTRL_WCOUNT_MSB = 7;
  localparam int unsigned CTRL_IOMEM_BIT  = 8;

  // ERROR_STATUS bit indices
  localparam int unsigned ERR_ZERO_COUNT = 0;
  localparam int unsigned ERR_UNMAPPED   = 1;
  localparam int unsigned ERR_CTRL_BUSY  = 2;

  localparam logic [DATA_W-1:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  // CTRL register image; reserved bits always read 0
  typedef struct packed {
    logic [DATA_W-CTRL_IOMEM_BIT-2:0] rsvd;
    logic                             io_mem;
    logic [WCOUNT_W-1:0]              w_count;
    logic                             start_dma;
  } ctrl_reg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eng_state_e;

endpackage

// File: rtl/modport_if.sv
// Single-cycle register bus between the register-model driver and the DMA block.
interface modport_if;
  import modport_pkg::*;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output wr_en, output rd_en, output addr, output wdata, input rdata);
  modport slave  (input wr_en, input rd_en, input addr, input wdata, output rdata);

endinterface

// File: rtl/modport_engine.sv
// DMA transfer engine: IDLE/RUN/DONE sequencer, countdown counter and
// running transfer-count accumulator. Busy lasts exactly len_i cycles.
module modport_engine
  import modport_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [WCOUNT_W-1:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   xfer_count_o,
  output logic                finish_c_o
);

  eng_state_e          state_q, state_d;
  logic [WCOUNT_W-1:0] cnt_q, cnt_d;
  logic [WCOUNT_W-1:0] len_q, len_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   tc_q, tc_d;
  logic                start_ok_c;
  logic                finish_c;

  assign start_ok_c = start_i && (len_i != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE may launch a new transfer directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok_c) state_d = RUN;
      RUN:     if (cnt_q == WCOUNT_W'(1)) state_d = DONE;
      DONE:    state_d = start_ok_c ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; completion is flagged on the RUN->DONE edge
  always_comb begin
    cnt_d    = cnt_q;
    len_d    = len_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tc_d     = tc_q;
    finish_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok_c) begin
          cnt_d  = len_i;
          len_d  = len_i;
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      RUN: begin
        cnt_d = cnt_q - WCOUNT_W'(1);
        if (cnt_q == WCOUNT_W'(1)) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          tc_d     = tc_q + DATA_W'(len_q);
          finish_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q  <= '0;
      len_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      busy_q <= busy_d;
      done_q <= done_d;
      tc_q   <= tc_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign xfer_count_o = tc_q;
  assign finish_c_o   = finish_c;

endmodule

// File: rtl/modport_dut.sv
// DMA controller register block: address decode, register file, W1C error
// status, registered read mux and the transfer engine.
// Optional: define MODPORT_UNMAPPED_ERR_EN to flag unmapped accesses in
// ERROR_STATUS[1] and return 32'hDEAD_BEEF on unmapped reads.
module modport_dut
  import modport_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0400
) (
  input logic      clk,
  input logic      rst_n,
  modport_if.slave bus
);

  logic [INTR_W-1:0] intr_status_q, intr_status_d;
  logic [INTR_W-1:0] intr_mask_q,   intr_mask_d;
  ctrl_reg_t         ctrl_q,        ctrl_d;
  logic [DATA_W-1:0] io_addr_q,     io_addr_d;
  logic [DATA_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] extra_q,       extra_d;
  logic [DATA_W-1:0] desc_addr_q,   desc_addr_d;
  logic [DATA_W-1:0] config_q,      config_d;
  logic [ERR_W-1:0]  err_q,         err_d;
  logic [DATA_W-1:0] rdata_q,       rdata_d;

  logic [ADDR_W-1:0] off_c;
  logic [OFF_W-1:0]  word_off_c;
  logic              hit_c;
  logic [DATA_W-1:0] rd_val_c;
  logic              wr_hit_c;
  logic              ctrl_wr_c;
  logic              ctrl_accept_c;
  logic              start_c;
  logic              zero_err_c;
  logic              busy_err_c;

  logic              eng_busy;
  logic              eng_done;
  logic [DATA_W-1:0] eng_tc;
  logic              eng_finish_c;

  // Offset relative to the block base; the two byte-lane bits are masked off
  assign off_c      = bus.addr - BASE_ADDR;
  assign word_off_c = off_c[OFF_W-1:0] & 8'hFC;

  // Address decode and read mux
  always_comb begin
    hit_c    = 1'b1;
    rd_val_c = '0;
    if (off_c[ADDR_W-1:OFF_W] != '0) begin
      hit_c = 1'b0;
    end else begin
      case (word_off_c)
        OFF_INTR:       rd_val_c = {intr_mask_q, intr_status_q};
        OFF_CTRL:       rd_val_c = ctrl_q;
        OFF_IO_ADDR:    rd_val_c = io_addr_q;
        OFF_MEM_ADDR:   rd_val_c = mem_addr_q;
        OFF_EXTRA_INFO: rd_val_c = extra_q;
        OFF_STATUS:     rd_val_c = {(DATA_W-3)'(0), |err_q, eng_done, eng_busy};
        OFF_XFER_COUNT: rd_val_c = eng_tc;
        OFF_DESC_ADDR:  rd_val_c = desc_addr_q;
        OFF_ERR_STATUS: rd_val_c = {(DATA_W-ERR_W)'(0), err_q};
        OFF_CONFIG:     rd_val_c = config_q;
        default:        hit_c    = 1'b0;
      endcase
    end
  end

  // CTRL writes are rejected wholesale while a transfer is running
  assign wr_hit_c      = bus.wr_en && hit_c;
  assign ctrl_wr_c     = wr_hit_c && (word_off_c == OFF_CTRL);
  assign ctrl_accept_c = ctrl_wr_c && !eng_busy;
  assign busy_err_c    = ctrl_wr_c && eng_busy;
  assign start_c       = ctrl_accept_c && bus.wdata[CTRL_START_BIT] &&
                         (bus.wdata[CTRL_WCOUNT_MSB:CTRL_WCOUNT_LSB] != '0);
  assign zero_err_c    = ctrl_accept_c && bus.wdata[CTRL_START_BIT] &&
                         (bus.wdata[CTRL_WCOUNT_MSB:CTRL_WCOUNT_LSB] == '0);

  // Register next-state: bus writes first, then hardware events that take priority
  always_comb begin
    intr_status_d = intr_status_q;
    intr_mask_d   = intr_mask_q;
    ctrl_d        = ctrl_q;
    io_addr_d     = io_addr_q;
    mem_addr_d    = mem_addr_q;
    extra_d       = extra_q;
    desc_addr_d   = desc_addr_q;
    config_d      = config_q;
    err_d         = err_q;
    rdata_d       = rdata_q;

    if (wr_hit_c) begin
      case (word_off_c)
        OFF_INTR:       {intr_mask_d, intr_status_d} = bus.wdata;
        OFF_IO_ADDR:    io_addr_d   = bus.wdata;
        OFF_MEM_ADDR:   mem_addr_d  = bus.wdata;
        OFF_EXTRA_INFO: extra_d     = bus.wdata;
        OFF_DESC_ADDR:  desc_addr_d = bus.wdata;
        OFF_CONFIG:     config_d    = bus.wdata;
        OFF_ERR_STATUS: err_d       = err_q & ~bus.wdata[ERR_W-1:0];
        default: ;
      endcase
    end

    if (ctrl_accept_c) begin
      ctrl_d.start_dma = bus.wdata[CTRL_START_BIT];
      ctrl_d.w_count   = bus.wdata[CTRL_WCOUNT_MSB:CTRL_WCOUNT_LSB];
      ctrl_d.io_mem    = bus.wdata[CTRL_IOMEM_BIT];
      ctrl_d.rsvd      = '0;
    end else if (eng_finish_c) begin
      ctrl_d.start_dma = 1'b0;
    end

    if (eng_finish_c) intr_status_d[0] = 1'b1;
    if (zero_err_c)   err_d[ERR_ZERO_COUNT] = 1'b1;
    if (busy_err_c)   err_d[ERR_CTRL_BUSY]  = 1'b1;

`ifdef MODPORT_UNMAPPED_ERR_EN
    if ((bus.wr_en || bus.rd_en) && !hit_c) err_d[ERR_UNMAPPED] = 1'b1;
    if (bus.rd_en) rdata_d = hit_c ? rd_val_c : UNMAPPED_RDATA;
`else
    err_d[ERR_UNMAPPED] = 1'b0;
    if (bus.rd_en) rdata_d = rd_val_c;
`endif
  end

  // Register file and read-data register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      intr_status_q <= '0;
      intr_mask_q   <= '0;
      ctrl_q        <= '0;
      io_addr_q     <= '0;
      mem_addr_q    <= '0;
      extra_q       <= '0;
      desc_addr_q   <= '0;
      config_q      <= '0;
      err_q         <= '0;
      rdata_q       <= '0;
    end else begin
      intr_status_q <= intr_status_d;
      intr_mask_q   <= intr_mask_d;
      ctrl_q        <= ctrl_d;
      io_addr_q     <= io_addr_d;
      mem_addr_q    <= mem_addr_d;
      extra_q       <= extra_d;
      desc_addr_q   <= desc_addr_d;
      config_q      <= config_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;

  modport_engine u_engine (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_c),
    .len_i        (bus.wdata[CTRL_WCOUNT_MSB:CTRL_WCOUNT_LSB]),
    .busy_o       (eng_busy),
    .done_o       (eng_done),
    .xfer_count_o (eng_tc),
    .finish_c_o   (eng_finish_c)
  );

endmodule

// File: tb/tb_modport_dut.sv
// Directed bench for the DMA register block: register access, read latency,
// transfer timing, error reporting, reset and unmapped accesses.
module tb_modport_dut;

  localparam logic [31:0] BASE   = 32'h0000_0400;
  localparam logic [31:0] A_INTR = BASE + 32'h00;
  localparam logic [31:0] A_CTRL = BASE + 32'h04;
  localparam logic [31:0] A_IO   = BASE + 32'h08;
  localparam logic [31:0] A_MEM  = BASE + 32'h0C;
  localparam logic [31:0] A_EXT  = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14;
  localparam logic [31:0] A_TC   = BASE + 32'h18;
  localparam logic [31:0] A_DESC = BASE + 32'h1C;
  localparam logic [31:0] A_ERR  = BASE + 32'h20;
  localparam logic [31:0] A_CFG  = BASE + 32'h24;
  localparam logic [31:0] A_UNM  = BASE + 32'h40;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  modport_if bus_if ();

  modport_dut #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.wr_en = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.rd_en = 1'b1;
    bus_if.addr  = a;
    @(negedge clk);
    bus_if.rd_en = 1'b0;
    d = bus_if.rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addrs [10];
    logic        found;

    clk          = 1'b0;
    rst_n        = 1'b1;
    tests_run    = 0;
    tests_failed = 0;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    addrs = '{A_INTR, A_CTRL, A_IO, A_MEM, A_EXT, A_STAT, A_TC, A_DESC, A_ERR, A_CFG};

    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    // Reset values of every register
    for (int i = 0; i < 10; i++) begin
      bus_read(addrs[i], rd);
      check($sformatf("reset_reg%0d", i), rd, 32'h0);
    end

    // Write/readback and one-cycle read latency with hold
    bus_write(A_IO, 32'h1234_5678);
    bus_write(A_EXT, 32'hA5A5_0000);
    bus_if.rd_en = 1'b1;
    bus_if.addr  = A_IO;
    #1;
    check("rdata_before_edge", bus_if.rdata, 32'h0);
    @(negedge clk);
    check("io_addr_readback", bus_if.rdata, 32'h1234_5678);
    bus_if.rd_en = 1'b0;
    bus_if.addr  = A_EXT;
    @(negedge clk);
    check("rdata_hold", bus_if.rdata, 32'h1234_5678);

    // Simultaneous read and write returns the old value
    bus_if.wr_en = 1'b1;
    bus_if.rd_en = 1'b1;
    bus_if.addr  = A_CFG;
    bus_if.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    check("rw_same_old", bus_if.rdata, 32'h0);
    bus_read(A_CFG, rd);
    check("rw_same_new", rd, 32'hCAFE_F00D);

    // Five-cycle transfer: busy for 5 cycles, then done
    bus_write(A_CTRL, 32'h0000_000B);
    bus_if.rd_en = 1'b1;
    bus_if.addr  = A_STAT;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("status_cyc%0d", i), bus_if.rdata, (i <= 5) ? 32'h1 : 32'h2);
    end
    bus_if.rd_en = 1'b0;
    bus_read(A_TC, rd);   check("tc_after_5", rd, 32'd5);
    bus_read(A_INTR, rd); check("intr_after_5", rd, 32'h1);
    bus_read(A_CTRL, rd); check("ctrl_selfclear", rd, 32'h0000_000A);

    // Read-only registers ignore writes
    bus_write(A_TC, 32'hFFFF_FFFF);
    bus_read(A_TC, rd);   check("tc_ro", rd, 32'd5);
    bus_write(A_STAT, 32'hFFFF_FFFF);
    bus_read(A_STAT, rd); check("status_ro", rd, 32'h2);

    // Zero-count start flags an error; W1C clears it
    bus_write(A_CTRL, 32'h0000_0001);
    bus_read(A_ERR, rd);  check("err_zero", rd, 32'h1);
    bus_read(A_STAT, rd); check("status_err", rd, 32'h6);
    bus_write(A_ERR, 32'h1);
    bus_read(A_ERR, rd);  check("err_cleared", rd, 32'h0);
    bus_read(A_STAT, rd); check("status_err_clr", rd, 32'h2);

    // CTRL write while busy is rejected and flagged
    bus_write(A_CTRL, 32'h0000_0015);
    bus_write(A_CTRL, 32'h0000_000B);
    bus_read(A_ERR, rd);  check("err_busy", rd, 32'h4);
    bus_read(A_STAT, rd); check("status_busy_err", rd, 32'h5);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      bus_read(A_STAT, rd);
      if (rd[1]) found = 1'b1;
    end
    check("done_within_budget", 32'(found), 32'h1);
    bus_read(A_TC, rd);   check("tc_after_10", rd, 32'd15);
    bus_read(A_CTRL, rd); check("ctrl_not_overwritten", rd, 32'h0000_0014);

    // Completion set of intr_status[0] wins over a same-cycle INTR write
    bus_write(A_INTR, 32'h0);
    bus_write(A_ERR, 32'h4);
    bus_write(A_CTRL, 32'h0000_0005);
    @(negedge clk);
    bus_write(A_INTR, 32'hABCD_0000);
    bus_read(A_INTR, rd); check("intr_set_wins", rd, 32'hABCD_0001);
    bus_read(A_TC, rd);   check("tc_after_2", rd, 32'd17);

    // CTRL reserved bits read 0; then reset in the middle of the transfer
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd); check("ctrl_mask", rd, 32'h0000_01FF);
    bus_read(A_STAT, rd); check("status_long_busy", rd, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    bus_read(A_TC, rd);   check("rst_tc", rd, 32'h0);
    bus_read(A_STAT, rd); check("rst_status", rd, 32'h0);
    bus_read(A_CTRL, rd); check("rst_ctrl", rd, 32'h0);
    bus_read(A_INTR, rd); check("rst_intr", rd, 32'h0);
    bus_read(A_CFG, rd);  check("rst_cfg", rd, 32'h0);
    bus_read(A_STAT, rd); check("rst_no_restart", rd, 32'h0);

    // Unmapped access
    bus_read(A_UNM, rd);
`ifdef MODPORT_UNMAPPED_ERR_EN
    check("unmapped_rdata", rd, 32'hDEAD_BEEF);
    bus_read(A_ERR, rd);  check("unmapped_err", rd, 32'h2);
    bus_read(A_STAT, rd); check("unmapped_status", rd, 32'h4);
`else
    check("unmapped_rdata", rd, 32'h0);
    bus_read(A_ERR, rd);  check("unmapped_err", rd, 32'h0);
    bus_read(A_STAT, rd); check("unmapped_status", rd, 32'h0);
`endif
    bus_write(A_UNM, 32'h1111_1111);
    bus_read(A_CFG, rd);  check("unmapped_wr_ignored", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
